// File: rtl/key_event_decoder_if.sv
// rtl/key_event_decoder_if.sv - key level in, event pulses out, for one button
interface key_event_decoder_if;
  logic key_in;
  logic press_pulse;
  logic release_pulse;
  logic short_click;
  logic long_press;
  logic repeat_pulse;
  logic hold_active;

  modport master (
    output key_in,
    input  press_pulse,
    input  release_pulse,
    input  short_click,
    input  long_press,
    input  repeat_pulse,
    input  hold_active
  );

  modport slave (
    input  key_in,
    output press_pulse,
    output release_pulse,
    output short_click,
    output long_press,
    output repeat_pulse,
    output hold_active
  );
endinterface

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - debounced active-low key to press/release/click/long/repeat events
module key_event_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  key_event_decoder_if.slave  bus
);

  localparam logic [1:0] ST_DISARM  = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_HELD    = 2'd3;

  // The press edge is hold sample 1, so PRESSED terminates one count early.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_DISARM;
      cnt               <= '0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_click   <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.hold_active   <= 1'b0;
    end else begin
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_click   <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      case (state)
        ST_DISARM: begin
          cnt <= '0;
          if (bus.key_in) state <= ST_IDLE;
        end
        ST_IDLE: begin
          cnt <= '0;
          if (!bus.key_in) begin
            state           <= ST_PRESSED;
            bus.press_pulse <= 1'b1;
          end
        end
        ST_PRESSED: begin
          // Release wins over a coincident long-press terminal count.
          if (bus.key_in) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.short_click   <= 1'b1;
          end else if (cnt == LONG_TC) begin
            state           <= ST_HELD;
            cnt             <= '0;
            bus.long_press  <= 1'b1;
            bus.hold_active <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (bus.key_in) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bus.release_pulse <= 1'b1;
            bus.hold_active   <= 1'b0;
          end else if (cnt == REPEAT_TC) begin
            cnt              <= '0;
            bus.repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state           <= ST_DISARM;
          cnt             <= '0;
          bus.hold_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
